pkt_arbiter: RTL
================

# pkt_arbiter

Packet-granularity round-robin arbiter that shares the write port of the packet FIFO (8-bit data plus SOF/EOF flag lanes) among NUM_REQ byte-stream sources. It grants one source for a whole SOF..EOF packet, forwards its bytes to the FIFO write side under `full` backpressure, and enforces a maximum packet length. On overlength it truncates with a forced EOF and drains the remainder. It sits between the UDP packet sources and the FIFO's write port, in the write clock domain.

## Interface
- NUM_REQ, 4, number of requesting sources (>=2)
- MAX_PKT_LEN, 1500, max bytes written per packet (>=2); longer packets are truncated
- CNT_WIDTH, 16, width of the packet counter
- clk  input  1  clock (the FIFO write clock)
- reset  input  1  reset; one clock, reset is synchronous and active-high
- in_valid  input  NUM_REQ  per-source byte valid
- in_sof  input  NUM_REQ  per-source first-byte flag
- in_eof  input  NUM_REQ  per-source last-byte flag
- in_data  input  8*NUM_REQ  per-source byte; source i at [8i+7:8i]
- in_ready  output  NUM_REQ  per-source byte accepted (transfer = valid & ready)
- wr_en  output  1  FIFO write enable
- wr_sof  output  1  FIFO SOF flag
- wr_eof  output  1  FIFO EOF flag
- din  output  8  FIFO data
- full  input  1  FIFO full
- grant  output  NUM_REQ  one-hot current owner, 0 when idle
- busy  output  1  state != IDLE
- trunc_err  output  1  one-cycle pulse on truncation
- pkt_cnt  output  CNT_WIDTH  packets written (including truncated ones), wraps

## Operation
- States: IDLE, BUSY, DRAIN. Reset forces IDLE with grant=0, rr_ptr=0, byte_cnt=0, pkt_cnt=0, trunc_err=0. During reset, in_ready=0 and wr_en=0.
- IDLE
  - A request is req[i] = in_valid[i] & in_sof[i].
  - Winner: first set req at or after rr_ptr, wrapping around.
  - On a winner: next state BUSY, grant <= onehot(winner), rr_ptr <= (winner+1) mod NUM_REQ, byte_cnt <= 0.
  - Stray bytes are discarded for resync: in_ready[i] = in_valid[i] & ~in_sof[i]; wr_en=0.
- BUSY, owner g
  - in_ready[g] = ~full; in_ready[i≠g]=0.
  - Transfer when in_valid[g] & ~full. On a transfer:
    - wr_en=1, din=in_data[g].
    - wr_sof = (byte_cnt==0), regardless of in_sof; in_sof on later bytes is ignored.
    - wr_eof = in_eof[g] | (byte_cnt==MAX_PKT_LEN-1).
    - byte_cnt increments.
  - Transfer with in_eof[g]: pkt_cnt++, go to IDLE, grant<=0.
  - Forced EOF without in_eof[g]: pkt_cnt++, trunc_err pulses next cycle, go to DRAIN.
- DRAIN
  - in_ready[g]=1, wr_en=0.
  - Discard bytes until in_valid[g] & in_eof[g], then go to IDLE, grant<=0.
- full held high mid-packet: hold indefinitely, with no timeout and no loss.
- wr_* and din are combinational from the granted source; all control state is registered.

## Timing
- Grant latency: SOF presented in cycle n (IDLE) → grant and busy high at n+1, and the first byte is written in cycle n+1 if ~full.
- Packet of L ≤ MAX_PKT_LEN bytes with no stalls occupies L+1 cycles, including the IDLE arbitration cycle.
- Back-to-back packets from different sources: one IDLE cycle between them.
- Simultaneous requests: only one grant; the rest keep SOF valid and wait.
- EOF on the same byte as byte_cnt==MAX_PKT_LEN-1: normal EOF; no trunc_err, no DRAIN.
- Single-byte packet (SOF and EOF together): wr_sof=wr_eof=1 in one write.
- pkt_cnt wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-packet: next cycle in IDLE. The downstream FIFO shares this reset, so no partial packet survives.
- byte_cnt width: $clog2(MAX_PKT_LEN+1).

## Structure
- Package pkt_arb_pkg holds:
  - state enum typedef {IDLE, BUSY, DRAIN}
  - BYTE_W=8 constant
- Sub-module rr_picker: combinational find-first-set from a rotating pointer. Inputs are req and ptr; outputs are a one-hot winner, its index, and any.

## Test plan
- Single source 0, 4-byte packet, full=0 → grant=0001 at n+1; 4 writes with wr_sof only on byte 0, wr_eof only on byte 3; pkt_cnt=1; busy low at n+5.
- Sources 0,1,2 present SOF simultaneously, rr_ptr=0 → grant order 0,1,2 with one IDLE cycle between packets; then a new request on 0 and 3 → 3 granted first.
- full toggles high for 3 cycles mid-packet → no write and in_ready[g]=0 while full; byte order and flags preserved; no bytes lost.
- MAX_PKT_LEN=8, source sends 12 bytes → 8 writes with wr_eof on the 8th; trunc_err pulses once; 4 bytes drained; pkt_cnt=1; next packet written normally.
- Stray bytes without SOF on idle source 2 → in_ready[2]=1, wr_en=0, pkt_cnt unchanged.
- reset asserted after byte 2 of a 6-byte packet → next cycle grant=0, busy=0, pkt_cnt=0; a fresh SOF from source 1 is granted (rr_ptr=0 scan).

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet-granularity FIFO write-port arbiter.
package pkt_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One beat on the FIFO write side.
  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [BYTE_W-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/pkt_arbiter_rr_picker.sv
// Round-robin find-first-set: lowest set request at or after i_ptr, wrapping around.
module rr_picker
  import pkt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan a doubled request window downwards so the last hit is the first one at/after i_ptr.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 2 * int'(NUM_REQ) - 1; k >= 0; k--) begin
      if ((k >= int'(i_ptr)) && (k < int'(i_ptr) + int'(NUM_REQ)) && i_req[k % NUM_REQ]) begin
        o_any = 1'b1;
        o_idx = PTR_W'(k % NUM_REQ);
      end
    end
    o_winner = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/pkt_arbiter.sv
// Packet-granularity round-robin arbiter for the packet FIFO write port, with
// maximum-length truncation (forced EOF) and drain of the overlength remainder.
module pkt_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_PKT_LEN = 1500,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_sof,
  input  logic [NUM_REQ-1:0]        in_eof,
  input  logic [BYTE_W*NUM_REQ-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      wr_en,
  output logic                      wr_sof,
  output logic                      wr_eof,
  output logic [BYTE_W-1:0]         din,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      trunc_err,
  output logic [CNT_WIDTH-1:0]      pkt_cnt
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned BCNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(MAX_PKT_LEN - 1);

  state_e               r_state, w_state_nx;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nx;
  logic [PTR_W-1:0]     r_gidx, w_gidx_nx;
  logic [PTR_W-1:0]     r_rr_ptr, w_ptr_nx;
  logic [BCNT_W-1:0]    r_byte_cnt, w_bcnt_nx;
  logic [CNT_WIDTH-1:0] r_pkt_cnt, w_pkt_nx;
  logic                 r_trunc_err, w_trunc_nx;

  logic [BYTE_W-1:0]    w_data [NUM_REQ];
  logic [NUM_REQ-1:0]   w_req;
  logic [NUM_REQ-1:0]   w_winner;
  logic [PTR_W-1:0]     w_widx;
  logic                 w_any;
  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_wr;
  logic                 w_force;
  wr_beat_t             w_beat;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign w_data[i] = in_data[i*BYTE_W +: BYTE_W];
  end

  assign w_req = in_valid & in_sof;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req    (w_req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_idx    (w_widx),
    .o_any    (w_any)
  );

  // Next-state and write-side datapath.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_gidx_nx  = r_gidx;
    w_ptr_nx   = r_rr_ptr;
    w_bcnt_nx  = r_byte_cnt;
    w_pkt_nx   = r_pkt_cnt;
    w_trunc_nx = 1'b0;
    w_ready    = '0;
    w_wr       = 1'b0;
    w_force    = 1'b0;
    w_beat     = '{sof: 1'b0, eof: 1'b0, data: w_data[r_gidx]};

    unique case (r_state)
      IDLE: begin
        // Bytes arriving without SOF are swallowed so a source can resync.
        w_ready = in_valid & ~in_sof;
        if (w_any) begin
          w_state_nx = BUSY;
          w_grant_nx = w_winner;
          w_gidx_nx  = w_widx;
          w_ptr_nx   = (w_widx == PTR_W'(NUM_REQ - 1)) ? '0 : w_widx + PTR_W'(1);
          w_bcnt_nx  = '0;
        end
      end
      BUSY: begin
        w_ready[r_gidx] = ~full;
        if (in_valid[r_gidx] && !full) begin
          w_wr        = 1'b1;
          w_force     = (r_byte_cnt == LAST_IDX);
          w_beat.sof  = (r_byte_cnt == '0);
          w_beat.eof  = in_eof[r_gidx] | w_force;
          w_bcnt_nx   = r_byte_cnt + BCNT_W'(1);
          if (in_eof[r_gidx]) begin
            w_pkt_nx   = r_pkt_cnt + CNT_WIDTH'(1);
            w_state_nx = IDLE;
            w_grant_nx = '0;
          end else if (w_force) begin
            w_pkt_nx   = r_pkt_cnt + CNT_WIDTH'(1);
            w_trunc_nx = 1'b1;
            w_state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_ready[r_gidx] = 1'b1;
        if (in_valid[r_gidx] && in_eof[r_gidx]) begin
          w_state_nx = IDLE;
          w_grant_nx = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_byte_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_trunc_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_gidx      <= w_gidx_nx;
      r_rr_ptr    <= w_ptr_nx;
      r_byte_cnt  <= w_bcnt_nx;
      r_pkt_cnt   <= w_pkt_nx;
      r_trunc_err <= w_trunc_nx;
    end
  end

  // Handshakes are held off while reset is asserted.
  assign in_ready  = reset ? '0 : w_ready;
  assign wr_en     = w_wr & ~reset;
  assign wr_sof    = w_beat.sof;
  assign wr_eof    = w_beat.eof;
  assign din       = w_beat.data;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);
  assign trunc_err = r_trunc_err;
  assign pkt_cnt   = r_pkt_cnt;

endmodule
